// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types and constants for the SPI controller
package spi_pkg;

    localparam int DATA_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SHIFT = 2'd2,
        HOLD  = 2'd3
    } spi_state_t;

    // {CKP, CPH}
    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

endpackage

// File: rtl/spi_clk_gen.sv
// rtl/spi_clk_gen.sv - SCK divider with leading/trailing edge strobes
module spi_clk_gen #(
    parameter int DIV = 2
) (
    input  logic CLK,
    input  logic RESET,
    input  logic i_en,
    input  logic i_ckp,
    output logic o_sck,
    output logic o_lead_edge,
    output logic o_trail_edge
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(DIV - 1);

    logic [CW-1:0] r_cnt;
    logic          r_sck;
    logic          w_tick;

    // Strobes fire in the cycle whose closing CLK edge registers the SCK toggle.
    assign w_tick       = i_en && (r_cnt == C_LAST);
    assign o_lead_edge  = w_tick && (r_sck == i_ckp);
    assign o_trail_edge = w_tick && (r_sck != i_ckp);
    assign o_sck        = r_sck;

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_cnt <= '0;
            r_sck <= 1'b0;
        end else if (!i_en) begin
            r_cnt <= '0;
            r_sck <= i_ckp;
        end else if (w_tick) begin
            r_cnt <= '0;
            r_sck <= ~r_sck;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/spi_controller.sv
// rtl/spi_controller.sv - SPI master, one full-duplex MSB-first frame per start
module spi_controller
    import spi_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DIV    = 2
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              start,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              CKP,
    input  logic              CPH,
    input  logic              MISO,
    output logic              SCK,
    output logic              SS,
    output logic              MOSI,
    output logic [DATA_W-1:0] rx_data,
    output logic              busy,
    output logic              done
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] C_DIV_LAST  = CW'(DIV - 1);
    localparam logic [5:0]    C_EDGE_LAST = 6'(2 * DATA_W - 1);

    spi_state_t        r_state;
    spi_state_t        w_next;
    logic [DATA_W-1:0] r_tx;
    logic [DATA_W-1:0] r_rx;
    logic [DATA_W-1:0] r_rx_data;
    logic [5:0]        r_edge_cnt;
    logic [CW-1:0]     r_hold_cnt;
    logic              r_ckp;
    logic              r_cph;
    logic              r_ss;
    logic              r_mosi;
    logic              r_busy;
    logic              r_done;

    logic w_en;
    logic w_ckp;
    logic w_lead;
    logic w_trail;
    logic w_edge;
    logic w_last_edge;
    logic w_hold_done;
    logic w_sample;
    logic w_shift_tx;

    assign w_en        = (r_state == SETUP) || (r_state == SHIFT);
    assign w_ckp       = (r_state == IDLE) ? CKP : r_ckp;
    assign w_edge      = w_lead || w_trail;
    assign w_last_edge = (r_edge_cnt == C_EDGE_LAST);
    assign w_hold_done = (r_state == HOLD) && (r_hold_cnt == C_DIV_LAST);
    assign w_sample    = r_cph ? w_trail : w_lead;
    // With CPH=0 the first bit is already on MOSI at SETUP, so the final trailing edge has nothing left to present.
    assign w_shift_tx  = r_cph ? w_lead : (w_trail && !w_last_edge);

    spi_clk_gen #(
        .DIV (DIV)
    ) u_clk_gen (
        .CLK          (CLK),
        .RESET        (RESET),
        .i_en         (w_en),
        .i_ckp        (w_ckp),
        .o_sck        (SCK),
        .o_lead_edge  (w_lead),
        .o_trail_edge (w_trail)
    );

    always_ff @(posedge CLK) begin
        if (!RESET) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = SETUP;
            SETUP:   if (w_edge) w_next = SHIFT;
            SHIFT:   if (w_edge && w_last_edge) w_next = HOLD;
            HOLD:    if (w_hold_done) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_tx       <= '0;
            r_rx       <= '0;
            r_rx_data  <= '0;
            r_edge_cnt <= '0;
            r_hold_cnt <= '0;
            r_ckp      <= 1'b0;
            r_cph      <= 1'b0;
            r_ss       <= 1'b1;
            r_mosi     <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_ss   <= 1'b1;
                    r_mosi <= 1'b0;
                    r_busy <= 1'b0;
                    if (start) begin
                        // CPH=0 presents the MSB now, so the shift register starts one bit ahead.
                        r_tx       <= CPH ? tx_data : (tx_data << 1);
                        r_mosi     <= CPH ? 1'b0 : tx_data[DATA_W-1];
                        r_ckp      <= CKP;
                        r_cph      <= CPH;
                        r_ss       <= 1'b0;
                        r_busy     <= 1'b1;
                        r_edge_cnt <= '0;
                        r_hold_cnt <= '0;
                        r_rx       <= '0;
                    end
                end
                SETUP, SHIFT: begin
                    if (w_edge)   r_edge_cnt <= r_edge_cnt + 6'd1;
                    if (w_sample) r_rx <= {r_rx[DATA_W-2:0], MISO};
                    if (w_shift_tx) begin
                        r_mosi <= r_tx[DATA_W-1];
                        r_tx   <= r_tx << 1;
                    end
                end
                HOLD: begin
                    r_hold_cnt <= r_hold_cnt + 1'b1;
                    if (w_hold_done) begin
                        r_ss      <= 1'b1;
                        r_done    <= 1'b1;
                        r_busy    <= 1'b0;
                        r_mosi    <= 1'b0;
                        r_rx_data <= r_rx;
                    end
                end
                default: ;
            endcase
        end
    end

    assign SS      = r_ss;
    assign MOSI    = r_mosi;
    assign rx_data = r_rx_data;
    assign busy    = r_busy;
    assign done    = r_done;

endmodule

// File: tb/tb_spi_controller.sv
// tb/tb_spi_controller.sv - directed self-checking bench for spi_controller
module tb_spi_controller;

    logic        CLK;
    logic        RESET;
    logic        start;
    logic [15:0] tx_data;
    logic        CKP;
    logic        CPH;
    logic        MISO;
    logic        sel;

    logic        start2, sck2, ss2, mosi2, busy2, done2;
    logic        start3, sck3, ss3, mosi3, busy3, done3;
    logic [15:0] rx2, rx3;
    logic        w_sck, w_ss, w_mosi, w_busy, w_done;
    logic [15:0] w_rx;

    int total = 0;
    int bad   = 0;

    int          done_cyc, first_ss, ss_low, edges, rises, mosi_bad, done_cnt;
    int          edge_cyc [3];
    logic [15:0] mosi_seq, rx_got;
    logic        sck_pre, sck_first, sck_end, busy1;
    int          dn, d1, d2, ss_hi;

    assign start2 = start && !sel;
    assign start3 = start && sel;
    assign w_sck  = sel ? sck3  : sck2;
    assign w_ss   = sel ? ss3   : ss2;
    assign w_mosi = sel ? mosi3 : mosi2;
    assign w_busy = sel ? busy3 : busy2;
    assign w_done = sel ? done3 : done2;
    assign w_rx   = sel ? rx3   : rx2;

    spi_controller #(.DATA_W(16), .DIV(2)) dut (
        .CLK(CLK), .RESET(RESET), .start(start2), .tx_data(tx_data), .CKP(CKP), .CPH(CPH),
        .MISO(MISO), .SCK(sck2), .SS(ss2), .MOSI(mosi2), .rx_data(rx2), .busy(busy2), .done(done2)
    );

    spi_controller #(.DATA_W(16), .DIV(3)) dut3 (
        .CLK(CLK), .RESET(RESET), .start(start3), .tx_data(tx_data), .CKP(CKP), .CPH(CPH),
        .MISO(MISO), .SCK(sck3), .SS(ss3), .MOSI(mosi3), .rx_data(rx3), .busy(busy3), .done(done3)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Runs one frame from an idle negedge; stops at the negedge of the done cycle.
    task automatic run_frame(input logic [15:0] tx, input logic ckp, input logic cph,
                             input bit loop, input logic [15:0] tgt, input bit mid);
        logic p_sck, p_mosi, p_ss, lead;
        int   idx;
        CKP = ckp; CPH = cph; tx_data = tx;
        @(negedge CLK);
        sck_pre = w_sck;
        start = 1'b1;
        done_cyc = -1; first_ss = -1; ss_low = 0; edges = 0; rises = 0;
        mosi_bad = 0; done_cnt = 0; mosi_seq = '0; rx_got = '0;
        sck_first = 1'bx; sck_end = 1'bx; busy1 = 1'bx;
        for (int i = 0; i < 3; i++) edge_cyc[i] = -1;
        p_sck = w_sck; p_mosi = w_mosi; p_ss = w_ss; idx = 15;
        @(posedge CLK);
        for (int n = 1; n <= 300 && done_cyc < 0; n++) begin
            @(negedge CLK);
            start = 1'b0;
            if (n == 1) begin sck_first = w_sck; busy1 = w_busy; end
            if (!w_ss) begin
                ss_low++;
                if (first_ss < 0) first_ss = n;
            end
            lead = (w_sck != ckp);
            if (w_sck != p_sck) begin
                if (edges < 3) edge_cyc[edges] = n;
                edges++;
                if (w_sck) rises++;
                if (lead == !cph) mosi_seq = {mosi_seq[14:0], w_mosi};
            end
            if (w_mosi != p_mosi && !w_ss && !p_ss)
                if (!(w_sck != p_sck && lead == cph)) mosi_bad++;
            if (w_done) begin
                done_cnt++; done_cyc = n; rx_got = w_rx; sck_end = w_sck;
            end
            if (mid && n == 20) begin CKP = ~ckp; tx_data = ~tx; end
            if (loop) MISO = w_mosi;
            else if (!w_ss && p_ss) begin
                idx = 15;
                if (!cph) begin MISO = tgt[15]; idx = 14; end
            end else if (!w_ss && w_sck != p_sck && idx >= 0 && lead == cph) begin
                MISO = tgt[idx];
                idx--;
            end
            p_sck = w_sck; p_mosi = w_mosi; p_ss = w_ss;
        end
        if (mid) CKP = ckp;
    endtask

    initial begin
        CLK = 0; RESET = 0; start = 0; tx_data = '0; CKP = 0; CPH = 0; MISO = 0; sel = 0;
        repeat (3) @(negedge CLK);
        chk("rst_sck", w_sck, 0);
        chk("rst_ss", w_ss, 1);
        chk("rst_mosi", w_mosi, 0);
        chk("rst_rx", w_rx, 0);
        chk("rst_busy", w_busy, 0);
        chk("rst_done", w_done, 0);
        RESET = 1;
        @(negedge CLK);

        run_frame(16'hA5C3, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0);
        chk("m0_done_cyc", done_cyc, 67);
        chk("m0_first_ss", first_ss, 1);
        chk("m0_ss_low", ss_low, 66);
        chk("m0_edges", edges, 32);
        chk("m0_rises", rises, 16);
        chk("m0_mosi_seq", mosi_seq, 16'hA5C3);
        chk("m0_rx", rx_got, 16'hA5C3);
        chk("m0_mosi_edge", mosi_bad, 0);
        chk("m0_busy1", busy1, 1);
        chk("m0_done_cnt", done_cnt, 1);
        chk("m0_busy_end", w_busy, 0);
        chk("m0_ss_end", w_ss, 1);

        for (int m = 1; m < 4; m++) begin
            logic [1:0] md;
            md = 2'(m);
            run_frame(16'h0F0F, md[1], md[0], 1'b0, 16'h3C96, 1'b0);
            chk($sformatf("m%0d_rx", m), rx_got, 16'h3C96);
            chk($sformatf("m%0d_mosi_edge", m), mosi_bad, 0);
            chk($sformatf("m%0d_mosi_seq", m), mosi_seq, 16'h0F0F);
            chk($sformatf("m%0d_sck_pre", m), sck_pre, md[1]);
            chk($sformatf("m%0d_sck_first", m), sck_first, md[1]);
            chk($sformatf("m%0d_sck_end", m), sck_end, md[1]);
            chk($sformatf("m%0d_done_cyc", m), done_cyc, 67);
        end

        // start held high across two frames
        tx_data = 16'h5555; CKP = 0; CPH = 0; start = 1;
        @(posedge CLK);
        dn = 0; d1 = -1; d2 = -1; ss_hi = 0;
        for (int n = 1; n <= 134; n++) begin
            @(negedge CLK);
            MISO = w_mosi;
            if (w_done) begin
                dn++;
                if (d1 < 0) d1 = n; else d2 = n;
            end
            if (n < 134 && w_ss) ss_hi++;
            if (n == 134) start = 0;
        end
        chk("b2b_done1", d1, 67);
        chk("b2b_done2", d2, 134);
        chk("b2b_done_cnt", dn, 2);
        chk("b2b_ss_gap", ss_hi, 1);
        chk("b2b_rx", w_rx, 16'h5555);

        // reset in the middle of a frame
        @(negedge CLK);
        tx_data = 16'hFFFF; CKP = 1; CPH = 0; start = 1;
        @(posedge CLK);
        for (int n = 1; n <= 20; n++) begin
            @(negedge CLK);
            start = 0;
            MISO = w_mosi;
        end
        RESET = 0;
        @(negedge CLK);
        chk("abort_ss", w_ss, 1);
        chk("abort_sck", w_sck, 0);
        chk("abort_busy", w_busy, 0);
        chk("abort_rx", w_rx, 0);
        chk("abort_done", w_done, 0);
        dn = 0;
        repeat (2) begin
            @(negedge CLK);
            if (w_done) dn++;
        end
        chk("abort_no_done", dn, 0);
        RESET = 1;
        run_frame(16'h8001, 1'b0, 1'b1, 1'b0, 16'hC3A5, 1'b0);
        chk("post_rst_rx", rx_got, 16'hC3A5);
        chk("post_rst_done_cyc", done_cyc, 67);
        chk("post_rst_mosi_seq", mosi_seq, 16'h8001);

        // DIV=3 instance, CKP and tx_data disturbed mid-frame
        @(negedge CLK);
        sel = 1;
        run_frame(16'h1234, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b1);
        chk("d3_edge0", edge_cyc[0], 4);
        chk("d3_edge1", edge_cyc[1], 7);
        chk("d3_edge2", edge_cyc[2], 10);
        chk("d3_edges", edges, 32);
        chk("d3_done_cyc", done_cyc, 100);
        chk("d3_rx", rx_got, 16'h1234);
        chk("d3_mosi_seq", mosi_seq, 16'h1234);
        chk("d3_sck_end", sck_end, 0);
        chk("d3_mosi_edge", mosi_bad, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
